// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
// Imported by the ALU datapath and by decode.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASSB = 4'b0000,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_AND   = 4'b0100,
    OP_OR    = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_ZERO  = 4'b0111,
    OP_LSL   = 4'b1000,
    OP_LSR   = 4'b1001,
    OP_ASR   = 4'b1010,
    OP_MUL   = 4'b1100
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational single-cycle ALU: ripple add/sub, logic ops, barrel shifts.
// Multiply is handled by the sequential wrapper; here it yields zero.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   cy;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   lsl;
  logic [WIDTH:0]   lsr;
  logic [WIDTH:0]   asr;

  // cy[i+1] is the carry out of bit i
  always_comb begin
    bx    = (op == OP_SUB) ? ~b : b;
    cy    = '0;
    cy[0] = (op == OP_SUB);
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = a[i] ^ bx[i] ^ cy[i];
      cy[i+1] = (a[i] & bx[i]) | (cy[i] & (a[i] ^ bx[i]));
    end
  end

  // An extra bit beside the operand catches the last bit shifted out
  assign sh  = b[SHW-1:0];
  assign lsl = {1'b0, a} << sh;
  assign lsr = {a, 1'b0} >> sh;
  assign asr = $unsigned($signed({a, 1'b0}) >>> sh);

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    unique case (op)
      OP_PASSB: result = b;
      OP_ADD, OP_SUB: begin
        result    = sum;
        carry_out = cy[WIDTH];
        overflow  = cy[WIDTH] ^ cy[WIDTH-1];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LSL: begin
        result    = lsl[WIDTH-1:0];
        carry_out = lsl[WIDTH];
      end
      OP_LSR: begin
        result    = lsr[WIDTH:1];
        carry_out = lsr[0];
      end
      OP_ASR: begin
        result    = asr[WIDTH:1];
        carry_out = asr[0];
      end
      default: result = '0;
    endcase
  end

  assign negative = result[WIDTH-1];
  assign zero     = ~|result;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops via alu_seq_core, iterative
// shift-and-add multiply, registered valid/ready result port.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   b_sh;

  logic [WIDTH-1:0] c_res;
  logic             c_neg;
  logic             c_zero;
  logic             c_ovf;
  logic             c_cy;
  logic             accept;

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a         (A),
    .b         (B),
    .op        (cntrl),
    .result    (c_res),
    .negative  (c_neg),
    .zero      (c_zero),
    .overflow  (c_ovf),
    .carry_out (c_cy)
  );

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Double-width accumulator keeps the high product half for overflow
  assign acc_nx = acc + (b_sh[0] ? a_sh : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && cntrl == OP_MUL) begin
            a_sh  <= {{WIDTH{1'b0}}, A};
            b_sh  <= B;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end else if (accept) begin
            result    <= c_res;
            negative  <= c_neg;
            zero      <= c_zero;
            overflow  <= c_ovf;
            carry_out <= c_cy;
            out_valid <= 1'b1;
          end
        end
        MUL: begin
          acc  <= acc_nx;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) begin
            result    <= acc_nx[WIDTH-1:0];
            negative  <= acc_nx[WIDTH-1];
            zero      <= ~|acc_nx[WIDTH-1:0];
            overflow  <= |acc_nx[2*WIDTH-1:WIDTH];
            carry_out <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8 and WIDTH=64 against an
// arithmetic reference model, with directed and random stimulus.
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, n8, z8, v8, c8;
  logic [7:0] a8, b8, r8;
  logic [3:0] op8;

  logic        iv64, ir64, ov64, or64, n64, z64, v64, c64;
  logic [63:0] a64, b64, r64;
  logic [3:0]  op64;

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .cntrl(op8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .negative(n8), .zero(z8),
    .overflow(v8), .carry_out(c8)
  );

  alu_seq #(.WIDTH(64)) u64 (
    .clk(clk), .reset(reset),
    .in_valid(iv64), .in_ready(ir64),
    .A(a64), .B(b64), .cntrl(op64),
    .out_valid(ov64), .out_ready(or64),
    .result(r64), .negative(n64), .zero(z64),
    .overflow(v64), .carry_out(c64)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] res;
    logic        n, z, v, c;
  } exp_t;

  // Reference: plain wide arithmetic, truncated to w bits
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b,
                                 logic [3:0] op);
    logic [127:0] m, x, y, full;
    int s;
    exp_t e;
    e = '0;
    m = (128'd1 << w) - 128'd1;
    x = {64'd0, a} & m;
    y = {64'd0, b} & m;
    s = int'(y[6:0]) & (w - 1);
    full = '0;
    case (op)
      4'b0000: full = y;
      4'b0010: begin
        full = x + y;
        e.c = full[w];
        e.v = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
      end
      4'b0011: begin
        full = x + (~y & m) + 128'd1;
        e.c = full[w];
        e.v = (x[w-1] != y[w-1]) && (full[w-1] != x[w-1]);
      end
      4'b0100: full = x & y;
      4'b0101: full = x | y;
      4'b0110: full = x ^ y;
      4'b1000: begin
        full = x << s;
        if (s != 0) e.c = full[w];
      end
      4'b1001: begin
        full = x >> s;
        if (s != 0) e.c = x[s-1];
      end
      4'b1010: begin
        full = x >> s;
        if (x[w-1]) full = full | (m & ~(m >> s));
        if (s != 0) e.c = x[s-1];
      end
      4'b1100: begin
        full = x * y;
        e.v = (full >> w) != 128'd0;
      end
      default: full = '0;
    endcase
    full  = full & m;
    e.res = full[63:0];
    e.n   = full[w-1];
    e.z   = (full == 128'd0);
    return e;
  endfunction

  function automatic logic rdy(int w);
    return (w == 8) ? ir8 : ir64;
  endfunction

  function automatic logic ovl(int w);
    return (w == 8) ? ov8 : ov64;
  endfunction

  task automatic check_out(int w, string tag, exp_t e);
    if (w == 8) begin
      check({tag, "_res"}, 64'(r8), e.res);
      check({tag, "_flg"}, 64'({n8, z8, v8, c8}),
            64'({e.n, e.z, e.v, e.c}));
    end else begin
      check({tag, "_res"}, r64, e.res);
      check({tag, "_flg"}, 64'({n64, z64, v64, c64}),
            64'({e.n, e.z, e.v, e.c}));
    end
  endtask

  // One op with out_ready held high; checks latency and busy in_ready
  task automatic run_op(int w, logic [63:0] a, logic [63:0] b,
                        logic [3:0] op, string tag);
    int k;
    int busy_rdy;
    exp_t e;
    e = model(w, a, b, op);
    @(negedge clk);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; op8 = op; iv8 = 1'b1; or8 = 1'b1;
    end else begin
      a64 = a; b64 = b; op64 = op; iv64 = 1'b1; or64 = 1'b1;
    end
    k = 0;
    while (!rdy(w) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_acc"}, 64'(k < 50), 64'd1);
    @(negedge clk);
    iv8 = 1'b0;
    iv64 = 1'b0;
    k = 0;
    busy_rdy = 0;
    while (!ovl(w) && k < 200) begin
      if (rdy(w)) busy_rdy++;
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 64'(k), (op == 4'b1100) ? 64'(w) : 64'd0);
    check({tag, "_busy"}, 64'(busy_rdy), 64'd0);
    check_out(w, tag, e);
  endtask

  exp_t q[$];
  exp_t e1, e2, ex;
  logic [11:0] prev_out;
  logic prev_stall;
  logic acc_last;
  int ghost;
  logic [3:0] ops64[6] = '{4'b0000, 4'b0100, 4'b0101,
                           4'b0110, 4'b0111, 4'b0001};
  logic [3:0] rops[14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                           4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hF};

  initial begin
    reset = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; op64 = '0; or64 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ov", 64'(ov8), 64'd0);
    check("rst_res", 64'(r8), 64'd0);
    check("rst_flg", 64'({n8, z8, v8, c8}), 64'd0);
    check("rst_rdy", 64'(ir8), 64'd1);
    check("rst_ov64", 64'(ov64), 64'd0);

    run_op(8, 64'h7F, 64'h01, 4'b0010, "add");
    run_op(8, 64'h05, 64'h05, 4'b0011, "sub");
    run_op(8, 64'h03, 64'h05, 4'b0011, "sub_bor");
    run_op(8, 64'h81, 64'h01, 4'b1000, "lsl");
    run_op(8, 64'h81, 64'h08, 4'b1000, "lsl0");
    run_op(8, 64'h81, 64'h03, 4'b1001, "lsr");
    run_op(8, 64'h80, 64'h0A, 4'b1010, "asr");
    run_op(8, 64'h10, 64'h11, 4'b1100, "mul_ov");
    run_op(8, 64'h0C, 64'h0B, 4'b1100, "mul");
    run_op(8, 64'h5A, 64'h33, 4'b1111, "ill");

    // Backpressure: result holds, second op waits, then both drain
    e1 = model(8, 64'h12, 64'h34, 4'b0010);
    e2 = model(8, 64'h0F, 64'hF0, 4'b0101);
    @(negedge clk);
    or8 = 1'b0; a8 = 8'h12; b8 = 8'h34; op8 = 4'b0010; iv8 = 1'b1;
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'hF0; op8 = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy", 64'(ir8), 64'd0);
      check("bp_ov", 64'(ov8), 64'd1);
      check_out(8, "bp_hold", e1);
      @(negedge clk);
    end
    or8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    check("bp_ov2", 64'(ov8), 64'd1);
    check_out(8, "bp_second", e2);
    @(negedge clk);
    check("bp_done", 64'(ov8), 64'd0);

    // Reset in the middle of a multiply
    a8 = 8'h0C; b8 = 8'h0B; op8 = 4'b1100; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_ov", 64'(ov8), 64'd0);
    check("mrst_res", 64'(r8), 64'd0);
    check("mrst_flg", 64'({n8, z8, v8, c8}), 64'd0);
    check("mrst_rdy", 64'(ir8), 64'd1);
    ghost = 0;
    for (int i = 0; i < 16; i++) begin
      if (ov8) ghost++;
      @(negedge clk);
    end
    check("mrst_ghost", 64'(ghost), 64'd0);

    // Random stream with random backpressure, in-order scoreboard
    acc_last = 1'b0;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk);
      #1;
      if (!iv8 || acc_last) begin
        a8  = 8'($urandom_range(0, 255));
        b8  = 8'($urandom_range(0, 255));
        op8 = rops[$urandom_range(0, 13)];
        iv8 = ($urandom_range(0, 3) != 0);
      end
      or8 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall)
        check("rs_hold", 64'({r8, n8, z8, v8, c8}), 64'(prev_out));
      if (ov8 && or8) begin
        check("rs_qnz", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          ex = q.pop_front();
          check_out(8, "rs", ex);
        end
      end
      prev_stall = ov8 && !or8;
      prev_out = {r8, n8, z8, v8, c8};
      acc_last = iv8 && ir8;
      if (acc_last) q.push_back(model(8, 64'(a8), 64'(b8), op8));
    end
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    or8 = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) begin
      @(negedge clk);
      if (ov8) begin
        ex = q.pop_front();
        check_out(8, "rs_drain", ex);
      end
    end
    check("rs_left", 64'(q.size()), 64'd0);

    for (int i = 0; i < 6; i++)
      run_op(64, {$urandom, $urandom}, {$urandom, $urandom},
             ops64[i], $sformatf("w64_op%0h", ops64[i]));
    run_op(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, "w64_addov");
    run_op(64, 64'h8000_0000_0000_0001, 64'd63, 4'b1010, "w64_asr");
    for (int i = 0; i < 8; i++)
      run_op(64, {$urandom, $urandom}, {$urandom, $urandom},
             rops[$urandom_range(0, 13)], $sformatf("w64_rnd%0d", i));
    run_op(64, {32'd0, $urandom}, {32'd0, $urandom}, 4'b1100, "w64_mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
